// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit timing and the FSM state encoding.
// The state encoding is also used by the transmit side, so keep the values
// stable.
//   BIT_CYCLES_DEF  : clk cycles per serial bit (24 MHz / 115200)
//   HALF_CYCLES_DEF : cycles from start-edge detect to the start-bit mid sample
//   uart_state_e    : IDLE=0, START=1, DATA=2, STOP=3, BRK=4
//   maj3()          : 2-of-3 vote, used by the optional sample filter
package uart_pkg;

    localparam int BIT_CYCLES_DEF  = 208;
    localparam int HALF_CYCLES_DEF = 104;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BRK   = 3'd4
    } uart_state_e;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the raw serial pin. Both flops reset to 1 so
// the line looks idle (high) coming out of reset and no false start edge
// is seen.
//   clk : system clock
//   rst : asynchronous reset, active-low
//   d   : asynchronous input
//   q   : synchronized output, 2-cycle latency
module uart_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] ff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ff <= 2'b11;
        end else begin
            ff <= {ff[0], d};
        end
    end

    assign q = ff[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Oversamples hwrx with a down-counter that is loaded
// with a half bit on the start edge and a full bit thereafter, so every
// sample lands near the bit centre. Good bytes are presented on
// rxchar/rxvalid until acknowledged; overrun and framing errors are sticky
// until err_clr.
//
// Build option: define UART_RX_MAJORITY_EN to sample through a 2-of-3 vote
// over a 3-cycle history of the synchronized line. Start-edge detection
// still uses the unfiltered line. Ports and timing are the same either way.
//
// Ports:
//   clk       : system clock
//   rst       : asynchronous reset, active-low
//   hwrx      : raw serial line, idle high
//   rxack     : 1-cycle pulse, consumer has taken rxchar
//   err_clr   : 1-cycle pulse, clear overrun and frame_err
//   rxchar    : last good byte, LSB first on the wire
//   rxvalid   : byte in rxchar not yet acknowledged
//   overrun   : sticky, good byte arrived while rxvalid=1 without ack
//   frame_err : sticky, stop-bit sample was 0
//   busy      : receiver not idle
//
// State | meaning
// IDLE  | waiting for a falling edge on the synchronized line
// START | half-bit wait, then confirm the start bit is still low
// DATA  | sampling 8 data bits, one per bit period
// STOP  | sampling the stop bit; high delivers the byte
// BRK   | stop bit was low; wait for the line to return high
module uart_rx
    import uart_pkg::*;
#(
    parameter int BIT_CYCLES  = BIT_CYCLES_DEF,
    parameter int HALF_CYCLES = HALF_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hwrx,
    input  logic       rxack,
    input  logic       err_clr,
    output logic [7:0] rxchar,
    output logic       rxvalid,
    output logic       overrun,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [7:0] HALF_LOAD = 8'(HALF_CYCLES - 1);
    localparam logic [7:0] BIT_LOAD  = 8'(BIT_CYCLES - 1);

    uart_state_e state, state_nxt;
    logic        rx_s;
    logic        smp;
    logic [7:0]  cnt;
    logic [2:0]  bitidx;
    logic [7:0]  shift;
    logic        tick;

    logic        ld_half;
    logic        ld_bit;
    logic        idx_clr;
    logic        shift_en;
    logic        byte_good;
    logic        frame_set;

    uart_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (hwrx),
        .q   (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [2:0] hist;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= 3'b111;
        end else begin
            hist <= {hist[1:0], rx_s};
        end
    end

    assign smp = maj3(hist);
`else
    assign smp = rx_s;
`endif

    assign tick = (cnt == 8'd0);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (!rx_s)                 state_nxt = ST_START;
            ST_START: if (tick)                  state_nxt = smp ? ST_IDLE : ST_DATA;
            ST_DATA:  if (tick && bitidx == 3'd7) state_nxt = ST_STOP;
            ST_STOP:  if (tick)                  state_nxt = smp ? ST_IDLE : ST_BRK;
            ST_BRK:   if (rx_s)                  state_nxt = ST_IDLE;
            default:                             state_nxt = ST_IDLE;
        endcase
    end

    // Output / datapath control decode
    always_comb begin
        ld_half   = 1'b0;
        ld_bit    = 1'b0;
        idx_clr   = 1'b0;
        shift_en  = 1'b0;
        byte_good = 1'b0;
        frame_set = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                ld_half = !rx_s;
            end
            ST_START: begin
                if (tick && !smp) begin
                    ld_bit  = 1'b1;
                    idx_clr = 1'b1;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_en = 1'b1;
                    ld_bit   = 1'b1;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    byte_good = smp;
                    frame_set = !smp;
                end
            end
            default: ;
        endcase
    end

    // Bit timer: reloads only on a load request, otherwise counts down and
    // parks at zero so it can never wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 8'd0;
        end else if (ld_half) begin
            cnt <= HALF_LOAD;
        end else if (ld_bit) begin
            cnt <= BIT_LOAD;
        end else if (!tick) begin
            cnt <= cnt - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bitidx <= 3'd0;
            shift  <= 8'd0;
        end else begin
            if (idx_clr) begin
                bitidx <= 3'd0;
            end else if (shift_en && bitidx != 3'd7) begin
                bitidx <= bitidx + 3'd1;
            end
            if (shift_en) begin
                shift <= {smp, shift[7:1]};
            end
        end
    end

    // Delivery handshake and sticky error flags; a set always beats a
    // same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxchar    <= 8'd0;
            rxvalid   <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (byte_good) begin
                rxchar  <= shift;
                rxvalid <= 1'b1;
            end else if (rxack) begin
                rxvalid <= 1'b0;
            end

            if (byte_good && rxvalid && !rxack) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end

            if (frame_set) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames at 208 clk per bit. Stimulus pushes the
// expected byte into a queue; a monitor pops and compares whenever rxvalid
// is presented and then acknowledges it.
module tb_uart_rx;

    localparam int BITC = 208;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       hwrx = 1'b1;
    logic       rxack = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rxchar;
    logic       rxvalid;
    logic       overrun;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int fails = 0;
    int nexp = 0;
    int nrecv = 0;
    logic auto_ack = 1'b1;
    logic [7:0] exp_q[$];

    uart_rx dut (
        .clk       (clk),
        .rst       (rst),
        .hwrx      (hwrx),
        .rxack     (rxack),
        .err_clr   (err_clr),
        .rxchar    (rxchar),
        .rxvalid   (rxvalid),
        .overrun   (overrun),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic hold(input logic v, input int n);
        hwrx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Full frame: start, 8 data LSB first, stop. With glitch set, each data
    // bit is inverted for the one cycle that lands on the DUT's sample point.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic glitch);
        hold(1'b0, BITC);
        for (int i = 0; i < 8; i++) begin
            if (glitch) begin
                hold(d[i], 104);
                hold(~d[i], 1);
                hold(d[i], 103);
            end else begin
                hold(d[i], BITC);
            end
        end
        hold(stop_v, BITC);
    endtask

    task automatic expect_byte(input logic [7:0] b);
        exp_q.push_back(b);
        nexp++;
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
    endtask

    // Monitor / scoreboard
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst && rxvalid && auto_ack) begin
                nrecv++;
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected no byte at %0t", rxchar, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (rxchar !== e) begin
                        fails++;
                        $display("FAIL rxchar: got 0x%0h, expected 0x%0h at %0t", rxchar, e, $time);
                    end
                end
                rxack = 1'b1;
                @(posedge clk);
                #1 rxack = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 2000000");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rxchar", 32'(rxchar), 32'h0);
        chk("rst_rxvalid", 32'(rxvalid), 32'h0);
        chk("rst_flags", 32'({overrun, frame_err}), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b1;
        hold(1'b1, 20);

        // 0x55 with exact delivery latency
        expect_byte(8'h55);
        fork
            send_frame(8'h55, 1'b1, 1'b0);
            begin
                repeat (1978) @(posedge clk);
                #1 chk("lat_before", 32'(rxvalid), 32'h0);
                @(posedge clk);
                #1 chk("lat_at", 32'(rxvalid), 32'h1);
            end
        join
        hold(1'b1, 20);
        chk("busy_after_55", 32'(busy), 32'h0);

        // Overrun: two bytes without ack
        auto_ack = 1'b0;
        send_frame(8'hA3, 1'b1, 1'b0);
        hold(1'b1, 20);
        chk("first_A3", 32'(rxchar), 32'hA3);
        chk("no_overrun_yet", 32'(overrun), 32'h0);
        send_frame(8'h3C, 1'b1, 1'b0);
        hold(1'b1, 20);
        chk("overrun_set", 32'(overrun), 32'h1);
        expect_byte(8'h3C);
        auto_ack = 1'b1;
        hold(1'b1, 10);
        pulse_err_clr();
        chk("overrun_clr", 32'(overrun), 32'h0);
        hold(1'b1, 10);

        // Framing error and break hold
        send_frame(8'h00, 1'b0, 1'b0);
        hold(1'b0, 2 * BITC);
        chk("frame_err_set", 32'(frame_err), 32'h1);
        chk("fe_rxvalid", 32'(rxvalid), 32'h0);
        chk("brk_busy", 32'(busy), 32'h1);
        hold(1'b1, 30);
        chk("brk_exit", 32'(busy), 32'h0);
        pulse_err_clr();
        chk("frame_err_clr", 32'(frame_err), 32'h0);
        expect_byte(8'h7E);
        send_frame(8'h7E, 1'b1, 1'b0);
        hold(1'b1, 20);

        // Short low pulse rejected at the start-bit check
        hold(1'b0, 100);
        chk("glitch_busy", 32'(busy), 32'h1);
        hold(1'b1, 30);
        chk("glitch_idle", 32'(busy), 32'h0);
        chk("glitch_novalid", 32'(rxvalid), 32'h0);
        chk("glitch_flags", 32'({overrun, frame_err}), 32'h0);

        // Reset mid-frame
        auto_ack = 1'b0;
        send_frame(8'h5A, 1'b1, 1'b0);
        hold(1'b1, 20);
        chk("pre_rst_valid", 32'(rxvalid), 32'h1);
        fork
            send_frame(8'hFF, 1'b1, 1'b0);
            begin
                repeat (104 + 3 * BITC) @(posedge clk);
                #2 chk("pre_rst_busy", 32'(busy), 32'h1);
                rst = 1'b0;
                #1;
                chk("mid_rst_rxchar", 32'(rxchar), 32'h0);
                chk("mid_rst_rxvalid", 32'(rxvalid), 32'h0);
                chk("mid_rst_busy", 32'(busy), 32'h0);
                chk("mid_rst_flags", 32'({overrun, frame_err}), 32'h0);
                repeat (3) @(posedge clk);
                #1 rst = 1'b1;
            end
        join
        hold(1'b1, 20);
        chk("post_rst_idle", 32'(busy), 32'h0);
        chk("post_rst_novalid", 32'(rxvalid), 32'h0);
        auto_ack = 1'b1;
        expect_byte(8'h81);
        send_frame(8'h81, 1'b1, 1'b0);
        hold(1'b1, 20);

        // Sample-point glitches: filtered build keeps 0x0F, raw build inverts
`ifdef UART_RX_MAJORITY_EN
        expect_byte(8'h0F);
`else
        expect_byte(8'hF0);
`endif
        send_frame(8'h0F, 1'b1, 1'b1);
        hold(1'b1, 20);

        waited = 0;
        while (exp_q.size() != 0 && waited < 5000) begin
            @(posedge clk);
            waited++;
        end
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        chk("byte_count", 32'(nrecv), 32'(nexp));
        chk("final_flags", 32'({overrun, frame_err}), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
